// File: rtl/wb_load_unit.sv
// Write-back stage: merges ALU results with in-order load responses, extends load data,
// and publishes a pending-destination mask. Optional macro WB_LD_BYPASS_EN writes a
// response that hits the head entry straight through when the ALU is idle.
module wb_load_unit #(
    parameter int LQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    input  logic [2:0]  ld_issue_funct3,
    input  logic [1:0]  ld_issue_addr_lo,
    output logic        ld_issue_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic [31:0] busy_mask,
    output logic        err_unexp
);
    localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);

    logic [4:0]    rd_q   [LQ_DEPTH];
    logic [2:0]    f3_q   [LQ_DEPTH];
    logic [1:0]    lo_q   [LQ_DEPTH];
    logic [31:0]   data_q [LQ_DEPTH];
    logic          dv_q   [LQ_DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_a3_q, rf_a3_d;
    logic [31:0]   rf_wd_q, rf_wd_d;
    logic          err_q;

    logic          push, pop, head_dv, bypass, store, resp_err;
    logic          tgt_found, wr_en;
    logic [PW-1:0] tgt_idx, scan_idx, busy_idx;
    logic [4:0]    wr_rd;
    logic [31:0]   wr_data;
    logic [31:0]   busy_c;

    function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lo);
        logic [31:0] bsh, hsh;
        bsh = w >> {lo, 3'b000};
        hsh = w >> {lo[1], 4'b0000};
        case (f3)
            3'b000:  ext_load = {{24{bsh[7]}}, bsh[7:0]};
            3'b001:  ext_load = {{16{hsh[15]}}, hsh[15:0]};
            3'b100:  ext_load = {24'h0, bsh[7:0]};
            3'b101:  ext_load = {16'h0, hsh[15:0]};
            default: ext_load = w;
        endcase
    endfunction

    assign ld_issue_ready = (count_q < DEPTH_C);
    assign push           = ld_issue && ld_issue_ready;
    assign head_dv        = (count_q != '0) && dv_q[head_q];

    always_comb begin
        tgt_found = 1'b0;
        tgt_idx   = head_q;
        scan_idx  = head_q;
        // Responses fill in order, so the target is the first tracked entry still lacking data.
        for (int i = 0; i < LQ_DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (!tgt_found && (CW'(i) < count_q) && !dv_q[scan_idx]) begin
                tgt_found = 1'b1;
                tgt_idx   = scan_idx;
            end
        end
`ifdef WB_LD_BYPASS_EN
        bypass = mem_rvalid && !alu_valid && tgt_found && (tgt_idx == head_q);
`else
        bypass = 1'b0;
`endif
        pop     = 1'b0;
        wr_en   = 1'b0;
        wr_rd   = 5'd0;
        wr_data = 32'd0;
        if (alu_valid) begin
            wr_en   = 1'b1;
            wr_rd   = alu_rd;
            wr_data = alu_data;
        end else if (head_dv) begin
            pop     = 1'b1;
            wr_en   = 1'b1;
            wr_rd   = rd_q[head_q];
            wr_data = ext_load(data_q[head_q], f3_q[head_q], lo_q[head_q]);
        end else if (bypass) begin
            pop     = 1'b1;
            wr_en   = 1'b1;
            wr_rd   = rd_q[head_q];
            wr_data = ext_load(mem_rdata, f3_q[head_q], lo_q[head_q]);
        end
        rf_we_d = wr_en && (wr_rd != 5'd0);
        rf_a3_d = rf_we_d ? wr_rd   : rf_a3_q;
        rf_wd_d = rf_we_d ? wr_data : rf_wd_q;

        store    = mem_rvalid && tgt_found && !bypass;
        resp_err = mem_rvalid && !tgt_found;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_comb begin
        busy_c   = 32'd0;
        busy_idx = head_q;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            busy_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (rd_q[busy_idx] != 5'd0)) busy_c[rd_q[busy_idx]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rf_we_q <= 1'b0;
            rf_a3_q <= 5'd0;
            rf_wd_q <= 32'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                rd_q[i]   <= 5'd0;
                f3_q[i]   <= 3'd0;
                lo_q[i]   <= 2'd0;
                data_q[i] <= 32'd0;
                dv_q[i]   <= 1'b0;
            end
        end else begin
            // Push slot, response target and popped head are always distinct entries.
            if (push) begin
                rd_q[tail_q] <= ld_issue_rd;
                f3_q[tail_q] <= ld_issue_funct3;
                lo_q[tail_q] <= ld_issue_addr_lo;
                dv_q[tail_q] <= 1'b0;
                tail_q       <= tail_q + 1'b1;
            end
            if (store) begin
                data_q[tgt_idx] <= mem_rdata;
                dv_q[tgt_idx]   <= 1'b1;
            end
            if (pop) head_q <= head_q + 1'b1;
            count_q <= count_d;
            rf_we_q <= rf_we_d;
            rf_a3_q <= rf_a3_d;
            rf_wd_q <= rf_wd_d;
            err_q   <= err_q | resp_err;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_a3     = rf_a3_q;
    assign rf_wd     = rf_wd_q;
    assign busy_mask = busy_c;
    assign err_unexp = err_q;
endmodule

// File: tb/tb_wb_load_unit.sv
// Self-checking bench for wb_load_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model. Honours WB_LD_BYPASS_EN if defined.
module tb_wb_load_unit;
    localparam int D = 2;
`ifdef WB_LD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        ld_issue = 1'b0;
    logic [4:0]  ld_issue_rd = '0;
    logic [2:0]  ld_issue_funct3 = '0;
    logic [1:0]  ld_issue_addr_lo = '0;
    logic        ld_issue_ready;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] busy_mask;
    logic        err_unexp;

    int n_checks = 0;
    int n_fail   = 0;

    wb_load_unit #(.LQ_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_funct3(ld_issue_funct3),
        .ld_issue_addr_lo(ld_issue_addr_lo), .ld_issue_ready(ld_issue_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .busy_mask(busy_mask), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] data;
        bit          dv;
    } ent_t;

    ent_t        pend[$];
    logic        m_we  = 1'b0;
    logic [4:0]  m_a3  = '0;
    logic [31:0] m_wd  = '0;
    logic        m_err = 1'b0;

    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        if (f3 == 3'd0)      return {{24{b[7]}}, b};
        else if (f3 == 3'd1) return {{16{h[15]}}, h};
        else if (f3 == 3'd4) return {24'h0, b};
        else if (f3 == 3'd5) return {16'h0, h};
        return w;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] m;
        m = 32'd0;
        foreach (pend[i]) if (pend[i].rd != 5'd0) m[pend[i].rd] = 1'b1;
        return m;
    endfunction

    function automatic bit m_has_nodata();
        foreach (pend[i]) if (!pend[i].dv) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        bit          wr, took, can_push, found;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        ent_t        e;
        if (rst) begin
            pend.delete();
            m_we = 1'b0; m_a3 = '0; m_wd = '0; m_err = 1'b0;
            return;
        end
        wr = 1'b0; took = 1'b0; found = 1'b0; wrd = '0; wdat = '0;
        can_push = (pend.size() < D);
        if (alu_valid) begin
            wr = 1'b1; wrd = alu_rd; wdat = alu_data;
        end else if (pend.size() > 0 && pend[0].dv) begin
            e = pend.pop_front();
            wr = 1'b1; wrd = e.rd; wdat = m_ext(e.data, e.f3, e.lo);
        end else if (BYP && mem_rvalid && pend.size() > 0) begin
            e = pend.pop_front();
            wr = 1'b1; wrd = e.rd; wdat = m_ext(mem_rdata, e.f3, e.lo); took = 1'b1;
        end
        if (mem_rvalid && !took) begin
            for (int i = 0; i < pend.size(); i++) begin
                if (!found && !pend[i].dv) begin
                    pend[i].data = mem_rdata; pend[i].dv = 1'b1; found = 1'b1;
                end
            end
            if (!found) m_err = 1'b1;
        end
        if (ld_issue && can_push) begin
            e.rd = ld_issue_rd; e.f3 = ld_issue_funct3; e.lo = ld_issue_addr_lo;
            e.data = '0; e.dv = 1'b0;
            pend.push_back(e);
        end
        m_we = wr && (wrd != 5'd0);
        if (m_we) begin m_a3 = wrd; m_wd = wdat; end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0; ld_issue_funct3 = '0; ld_issue_addr_lo = '0;
        mem_rvalid = 1'b0; mem_rdata = '0; rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
        ld_issue = 1'b1; ld_issue_rd = rd; ld_issue_funct3 = f3; ld_issue_addr_lo = lo;
    endtask

    task automatic respond(input logic [31:0] d);
        mem_rvalid = 1'b1; mem_rdata = d;
    endtask

    // First tick uses whatever the caller drove; lat = ticks until rf_we, 0 if none.
    task automatic wait_we(input int budget, output int lat);
        bit seen;
        seen = 1'b0; lat = 0;
        for (int k = 1; k <= budget; k++) begin
            if (!seen) begin
                tick();
                clear_inputs();
                if (rf_we === 1'b1) begin seen = 1'b1; lat = k; end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        clear_inputs();
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", rf_we); end
        n_checks++; if (rf_a3 !== 5'd0) begin n_fail++; $display("FAIL reset_a3: got %0d want 0", rf_a3); end
        n_checks++; if (rf_wd !== 32'd0) begin n_fail++; $display("FAIL reset_wd: got %h want 0", rf_wd); end
        n_checks++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
        n_checks++; if (err_unexp !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_unexp); end
        n_checks++; if (ld_issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ld_issue_ready); end
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        tick();
        clear_inputs();
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %b want 1", rf_we); end
        n_checks++; if (rf_a3 !== 5'd5) begin n_fail++; $display("FAIL alu_a3: got %0d want 5", rf_a3); end
        n_checks++; if (rf_wd !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_wd: got %h want 00001234", rf_wd); end
        tick();
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_idle_we: got %b want 0", rf_we); end
        n_checks++; if (rf_a3 !== 5'd5 || rf_wd !== 32'h1234) begin
            n_fail++; $display("FAIL alu_hold: got a3=%0d wd=%h want a3=5 wd=00001234", rf_a3, rf_wd);
        end
    endtask

    task automatic test_lb();
        int lat, exp_lat;
        exp_lat = BYP ? 1 : 2;
        issue(5'd7, 3'b000, 2'd2);
        tick();
        clear_inputs();
        n_checks++; if (busy_mask[7] !== 1'b1) begin n_fail++; $display("FAIL lb_busy_set: got %h want bit7", busy_mask); end
        respond(32'h0080_FF00);
        wait_we(4, lat);
        n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL lb_latency: got %0d want %0d", lat, exp_lat); end
        n_checks++; if (rf_a3 !== 5'd7) begin n_fail++; $display("FAIL lb_a3: got %0d want 7", rf_a3); end
        n_checks++; if (rf_wd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_wd: got %h want ffffff80", rf_wd); end
        n_checks++; if (busy_mask[7] !== 1'b0) begin n_fail++; $display("FAIL lb_busy_clr: got %h want bit7 clear", busy_mask); end
    endtask

    task automatic test_in_order();
        logic [36:0] exp_q[$];
        logic [36:0] e;
        exp_q.push_back({5'd3, 32'h0000_BEEF});
        exp_q.push_back({5'd4, 32'hCAFE_F00D});
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            case (c)
                0: issue(5'd3, 3'b101, 2'd2);
                1: issue(5'd4, 3'b010, 2'd0);
                2: respond(32'hBEEF_0000);
                3: respond(32'hCAFE_F00D);
                default: ;
            endcase
            tick();
            if (rf_we === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL order_extra: got a3=%0d wd=%h want no write", rf_a3, rf_wd);
                end else begin
                    e = exp_q.pop_front();
                    if ({rf_a3, rf_wd} !== e) begin
                        n_fail++; $display("FAIL order_write: got a3=%0d wd=%h want a3=%0d wd=%h",
                                           rf_a3, rf_wd, e[36:32], e[31:0]);
                    end
                end
            end
        end
        clear_inputs();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL order_missing: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_full();
        int lat;
        issue(5'd8, 3'b010, 2'd0); tick();
        issue(5'd9, 3'b010, 2'd0); tick();
        clear_inputs();
        n_checks++; if (ld_issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", ld_issue_ready); end
        issue(5'd10, 3'b010, 2'd0); tick();
        clear_inputs();
        n_checks++; if (busy_mask !== 32'h0000_0300) begin n_fail++; $display("FAIL full_ignore: got %h want 00000300", busy_mask); end
        respond(32'h0000_00AA);
        wait_we(4, lat);
        n_checks++; if (lat == 0 || rf_a3 !== 5'd8 || rf_wd !== 32'hAA) begin
            n_fail++; $display("FAIL full_pop1: got lat=%0d a3=%0d wd=%h want a3=8 wd=000000aa", lat, rf_a3, rf_wd);
        end
        n_checks++; if (ld_issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %b want 1", ld_issue_ready); end
        respond(32'h0000_00BB);
        wait_we(4, lat);
        n_checks++; if (lat == 0 || rf_a3 !== 5'd9 || rf_wd !== 32'hBB) begin
            n_fail++; $display("FAIL full_pop2: got lat=%0d a3=%0d wd=%h want a3=9 wd=000000bb", lat, rf_a3, rf_wd);
        end
        n_checks++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL full_drained: got %h want 0", busy_mask); end
    endtask

    task automatic test_alu_priority();
        issue(5'd12, 3'b010, 2'd0); tick();
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            if (c == 0) respond(32'h1122_3344);
            if (c < 3) begin alu_valid = 1'b1; alu_rd = 5'(c + 1); alu_data = 32'(c + 100); end
            tick();
            if (c < 3) begin
                n_checks++; if (rf_we !== 1'b1 || rf_a3 !== 5'(c + 1) || rf_wd !== 32'(c + 100)) begin
                    n_fail++; $display("FAIL prio_alu%0d: got we=%b a3=%0d wd=%h want we=1 a3=%0d wd=%h",
                                       c, rf_we, rf_a3, rf_wd, c + 1, c + 100);
                end
            end else begin
                n_checks++; if (rf_we !== 1'b1 || rf_a3 !== 5'd12 || rf_wd !== 32'h1122_3344) begin
                    n_fail++; $display("FAIL prio_load: got we=%b a3=%0d wd=%h want we=1 a3=12 wd=11223344",
                                       rf_we, rf_a3, rf_wd);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_unexp_rd0_reset();
        bit any_we;
        respond(32'hDEAD_BEEF); tick();
        clear_inputs();
        n_checks++; if (err_unexp !== 1'b1) begin n_fail++; $display("FAIL unexp_set: got %b want 1", err_unexp); end
        tick();
        n_checks++; if (err_unexp !== 1'b1) begin n_fail++; $display("FAIL unexp_sticky: got %b want 1", err_unexp); end
        any_we = 1'b0;
        issue(5'd0, 3'b010, 2'd0); tick(); clear_inputs();
        n_checks++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL rd0_busy: got %h want 0", busy_mask); end
        respond(32'h5555_5555); tick(); clear_inputs();
        any_we = any_we | rf_we;
        tick(); any_we = any_we | rf_we;
        tick(); any_we = any_we | rf_we;
        n_checks++; if (any_we !== 1'b0) begin n_fail++; $display("FAIL rd0_we: got 1 want 0"); end
        issue(5'd13, 3'b010, 2'd0); tick();
        issue(5'd14, 3'b010, 2'd0); tick();
        clear_inputs();
        n_checks++; if (ld_issue_ready !== 1'b0 || busy_mask !== 32'h0000_6000) begin
            n_fail++; $display("FAIL rd0_slot_freed: got ready=%b busy=%h want ready=0 busy=00006000",
                               ld_issue_ready, busy_mask);
        end
        n_checks++; if (err_unexp !== 1'b1) begin n_fail++; $display("FAIL unexp_still: got %b want 1", err_unexp); end
        rst = 1'b1; tick(); clear_inputs();
        n_checks++; if (busy_mask !== 32'd0 || ld_issue_ready !== 1'b1 || err_unexp !== 1'b0 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL midreset: got busy=%h ready=%b err=%b we=%b want 0/1/0/0",
                               busy_mask, ld_issue_ready, err_unexp, rf_we);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            clear_inputs();
            alu_valid = ($urandom_range(0, 99) < 30);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            ld_issue  = ($urandom_range(0, 99) < 45);
            ld_issue_rd      = 5'($urandom_range(0, 7));
            ld_issue_funct3  = 3'($urandom_range(0, 7));
            ld_issue_addr_lo = 2'($urandom_range(0, 3));
            mem_rvalid = m_has_nodata() && ($urandom_range(0, 99) < 50);
            mem_rdata  = $urandom;
            tick();
            n_checks++; if (rf_we !== m_we) begin n_fail++; $display("FAIL rnd_we c=%0d: got %b want %b", c, rf_we, m_we); end
            n_checks++; if (rf_a3 !== m_a3 || rf_wd !== m_wd) begin
                n_fail++; $display("FAIL rnd_data c=%0d: got a3=%0d wd=%h want a3=%0d wd=%h", c, rf_a3, rf_wd, m_a3, m_wd);
            end
            n_checks++; if (busy_mask !== m_busy()) begin
                n_fail++; $display("FAIL rnd_busy c=%0d: got %h want %h", c, busy_mask, m_busy());
            end
            n_checks++; if (ld_issue_ready !== (pend.size() < D)) begin
                n_fail++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, ld_issue_ready, pend.size() < D);
            end
            n_checks++; if (err_unexp !== m_err) begin
                n_fail++; $display("FAIL rnd_err c=%0d: got %b want %b", c, err_unexp, m_err);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb();
        test_in_order();
        test_full();
        test_alu_priority();
        test_unexp_rd0_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_load_unit.md
Name: wb_load_unit

Overview:
- Write-back stage directly upstream of the register file write port; drives we/a3/wd.
- Merges single-cycle ALU results with variable-latency data-memory load responses.
- Tracks issued loads in order and applies byte/halfword extension to load data.
- Publishes a pending-destination mask that the hazard logic uses to stall dependent reads.

Parameters:
LQ_DEPTH, 2, number of outstanding loads tracked (power of two, 2..8)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU result to write this cycle
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
ld_issue  input  1  load issued to data memory this cycle
ld_issue_rd  input  5  load destination register
ld_issue_funct3  input  3  load type (RV32I funct3)
ld_issue_addr_lo  input  2  byte address bits [1:0]
ld_issue_ready  output  1  queue can accept an issue
mem_rvalid  input  1  load response data valid
mem_rdata  input  32  raw word from data memory
rf_we  output  1  register file write enable
rf_a3  output  5  register file write address
rf_wd  output  32  register file write data
busy_mask  output  32  bit r set while a tracked load targets xr
err_unexp  output  1  sticky: response arrived with no load awaiting data

Behaviour:
- Reset (sync, rst=1 at edge): queue empty; rf_we=0, rf_a3=0, rf_wd=0, busy_mask=0, err_unexp=0. Reset mid-operation discards all tracked loads, including their data.
- Queue: circular, LQ_DEPTH entries of {rd, funct3, addr_lo, data, dvalid}, with head/tail pointers and a count.
- ld_issue_ready = (count < LQ_DEPTH). No credit for a same-cycle pop.
- Push: occurs when ld_issue && ld_issue_ready; dvalid=0. ld_issue while not ready is ignored.
- Response: mem_rvalid stores mem_rdata into the oldest entry with dvalid=0 and sets its dvalid (in-order memory). If no such entry exists, set err_unexp and drop the data.
- Write-back select (combinational), registered into rf_* at the edge:
  - alu_valid: write {alu_rd, alu_data}. ALU always has priority.
  - else, head dvalid=1: pop head and write {rd, extended data}.
  - else: rf_we=0.
- Outputs are registered. rf_a3/rf_wd hold their last value when rf_we=0.
- Latency:
  - ALU: alu_valid in cycle N gives rf_we=1 in cycle N+1.
  - Load: mem_rvalid in N gives data stored at the end of N; if head and no ALU in N+1, rf_we=1 in N+2.
- rd==0: ALU or load still consumes its slot, but rf_we is forced 0. busy_mask bit 0 is always 0.
- Extension by funct3 (byte lane = addr_lo, halfword = addr_lo[1]):
  - 000 LB sign-extend
  - 001 LH sign-extend
  - 010 LW
  - 100 LBU zero-extend
  - 101 LHU zero-extend
  - any other code: treated as LW.
- busy_mask = OR over valid entries of (1<<rd), excluding rd=0, computed from registered queue state. A bit clears the cycle after its entry pops; it stays set if another entry holds the same rd.
- Simultaneous push + pop + response in one cycle: all applied. Count is unchanged by push+pop. The response targets the oldest dvalid=0 entry after the pop is taken into account.
- ALU starvation of loads is allowed; the upstream pipeline guarantees bubbles.

Optional Feature:
WB_LD_BYPASS_EN:
- Defined: when mem_rvalid hits the head entry (head dvalid=0) and alu_valid=0 in the same cycle, the head is popped and its extended mem_rdata is written directly. Load latency becomes rf_we=1 in N+1.
- Undefined: the response is always stored first, giving a minimum latency of N+2.
- Ordering and err_unexp behaviour are identical in both builds.

Test Plan:
- Reset, then alu_valid rd=5 data=0x1234 in cycle 1 -> cycle 2: rf_we=1, rf_a3=5, rf_wd=0x00001234.
- Issue LB rd=7 addr_lo=2; rvalid rdata=0x0080FF00 -> rf_wd=0xFFFFFF80, rf_a3=7, at N+2 (N+1 with WB_LD_BYPASS_EN). busy_mask[7]=1 until the pop, 0 after.
- Issue LHU rd=3 addr_lo=2 then LW rd=4; responses 0xBEEF0000, 0xCAFEF00D -> writes x3=0x0000BEEF, then x4=0xCAFEF00D, in order.
- Fill LQ_DEPTH=2 loads -> ld_issue_ready=0; a third ld_issue is ignored. Pop one -> ready=1 the next cycle.
- Response ready at head while alu_valid held 3 cycles -> three ALU writes, then the load write in the 4th cycle.
- rvalid with empty queue -> err_unexp=1, sticky until rst. Load to rd=0 -> no rf_we, slot freed. rst mid-flight -> busy_mask=0, ready=1.
